// File: rtl/light_sequence_monitor.sv
// Sequence monitor for the 3-state light counter: synchronises q_in, drives lamps, flags faults.
// Optional macro MIN_DWELL_EN adds the minimum-dwell (err_short) check; otherwise err_short is 0.
module light_sequence_monitor #(
   parameter int DWELL_W   = 24,
   parameter int TIMEOUT   = 600000,
   parameter int MIN_DWELL = 262144
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         q_in,
   input  logic               clear_err,
   output logic               lamp_red,
   output logic               lamp_green,
   output logic               lamp_yellow,
   output logic               state_valid,
   output logic               step,
   output logic [DWELL_W-1:0] dwell,
   output logic               err_illegal,
   output logic               err_skip,
   output logic               err_timeout,
   output logic               err_short
);

   localparam logic [0:0] ST_INIT  = 1'b0;
   localparam logic [0:0] ST_TRACK = 1'b1;
   localparam logic [DWELL_W-1:0] TIMEOUT_M1 = DWELL_W'(TIMEOUT - 1);
   localparam logic [1:0] CODE_ILLEGAL = 2'b11;

   logic [1:0]         sync1_reg, s2_reg;
   logic [1:0]         prev_reg, prev_next;
   logic [0:0]         state_reg, state_next;
   logic [DWELL_W-1:0] dwell_reg, dwell_next;
   logic               red_reg, green_reg, yellow_reg;
   logic               valid_reg, valid_next;
   logic               step_reg, step_next;
   logic               ill_reg, skip_reg, to_reg;
   logic               ill_ev, skip_ev, to_ev;

   function automatic logic [1:0] next_code(input logic [1:0] c);
      case (c)
         2'b00:   next_code = 2'b01;
         2'b01:   next_code = 2'b10;
         default: next_code = 2'b00;
      endcase
   endfunction

   always_comb begin
      state_next = state_reg;
      prev_next  = prev_reg;
      dwell_next = dwell_reg;
      valid_next = 1'b0;
      step_next  = 1'b0;
      ill_ev     = 1'b0;
      skip_ev    = 1'b0;
      to_ev      = 1'b0;
      case (state_reg)
         ST_INIT: begin
            dwell_next = '0;
            if (s2_reg == CODE_ILLEGAL) begin
               ill_ev = 1'b1;
            end else begin
               prev_next  = s2_reg;
               state_next = ST_TRACK;
               valid_next = 1'b1;
            end
         end
         default: begin
            if (s2_reg == CODE_ILLEGAL) begin
               // prev is kept; INIT re-learns the code once it is legal again
               ill_ev     = 1'b1;
               dwell_next = '0;
               state_next = ST_INIT;
            end else if (s2_reg == prev_reg) begin
               valid_next = 1'b1;
               if (dwell_reg != '1)
                  dwell_next = dwell_reg + 1'b1;
               if (dwell_reg == TIMEOUT_M1)
                  to_ev = 1'b1;
            end else if (s2_reg == next_code(prev_reg)) begin
               valid_next = 1'b1;
               step_next  = 1'b1;
               dwell_next = '0;
               prev_next  = s2_reg;
            end else begin
               valid_next = 1'b1;
               skip_ev    = 1'b1;
               dwell_next = '0;
               prev_next  = s2_reg;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_reg  <= 2'b00;
         s2_reg     <= 2'b00;
         prev_reg   <= 2'b00;
         state_reg  <= ST_INIT;
         dwell_reg  <= '0;
         red_reg    <= 1'b1;
         green_reg  <= 1'b0;
         yellow_reg <= 1'b0;
         valid_reg  <= 1'b0;
         step_reg   <= 1'b0;
         ill_reg    <= 1'b0;
         skip_reg   <= 1'b0;
         to_reg     <= 1'b0;
      end else begin
         sync1_reg  <= q_in;
         s2_reg     <= sync1_reg;
         prev_reg   <= prev_next;
         state_reg  <= state_next;
         dwell_reg  <= dwell_next;
         red_reg    <= (s2_reg == 2'b00) || (s2_reg == CODE_ILLEGAL);
         green_reg  <= (s2_reg == 2'b01);
         yellow_reg <= (s2_reg == 2'b10);
         valid_reg  <= valid_next;
         step_reg   <= step_next;
         // a new event in the same cycle as clear_err keeps the flag set
         ill_reg    <= ill_ev  | (ill_reg  & ~clear_err);
         skip_reg   <= skip_ev | (skip_reg & ~clear_err);
         to_reg     <= to_ev   | (to_reg   & ~clear_err);
      end
   end

`ifdef MIN_DWELL_EN
   localparam logic [DWELL_W-1:0] MIN_DW = DWELL_W'(MIN_DWELL);
   logic short_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         short_reg <= 1'b0;
      else
         short_reg <= (step_next && (dwell_reg < MIN_DW)) | (short_reg & ~clear_err);
   end

   assign err_short = short_reg;
`else
   assign err_short = 1'b0;
`endif

   assign lamp_red    = red_reg;
   assign lamp_green  = green_reg;
   assign lamp_yellow = yellow_reg;
   assign state_valid = valid_reg;
   assign step        = step_reg;
   assign dwell       = dwell_reg;
   assign err_illegal = ill_reg;
   assign err_skip    = skip_reg;
   assign err_timeout = to_reg;

endmodule

// File: tb/tb_light_sequence_monitor.sv
// Directed, table-driven bench for light_sequence_monitor (TIMEOUT=16, MIN_DWELL=8).
module tb_light_sequence_monitor;

   localparam int DW = 24;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    q_in;
   logic          clear_err;
   logic          lamp_red, lamp_green, lamp_yellow;
   logic          state_valid, step;
   logic [DW-1:0] dwell;
   logic          err_illegal, err_skip, err_timeout, err_short;

   int errors = 0;
   int checks = 0;

   light_sequence_monitor #(.DWELL_W(DW), .TIMEOUT(16), .MIN_DWELL(8)) dut (
      .clk(clk), .reset(reset), .q_in(q_in), .clear_err(clear_err),
      .lamp_red(lamp_red), .lamp_green(lamp_green), .lamp_yellow(lamp_yellow),
      .state_valid(state_valid), .step(step), .dwell(dwell),
      .err_illegal(err_illegal), .err_skip(err_skip), .err_timeout(err_timeout),
      .err_short(err_short)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] q;
      logic       clr;
      int         n;
      logic [2:0] lamps;   // {red, green, yellow}
      logic       sv;
      logic       stp;
      int         dw;
      logic       ill;
      logic       skp;
      logic       tmo;
      logic       sh;      // err_short expected only when the minimum-dwell check is built
   } vec_t;

   vec_t tbl[$];

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] G = 3'b010;
   localparam logic [2:0] Y = 3'b001;

   task automatic add(input logic [1:0] q, input logic clr, input int n, input logic [2:0] lamps,
                      input logic sv, input logic stp, input int dw, input logic ill,
                      input logic skp, input logic tmo, input logic sh);
      vec_t v;
      v = '{q, clr, n, lamps, sv, stp, dw, ill, skp, tmo, sh};
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [2:0] lamps, input logic sv, input logic stp,
                        input int dw, input logic ill, input logic skp, input logic tmo, input logic sh);
      logic [8:0] act, exp;
      act = {lamp_red, lamp_green, lamp_yellow, state_valid, step, err_illegal, err_skip, err_timeout, err_short};
      exp = {lamps, sv, stp, ill, skp, tmo, sh};
      checks++;
      if (act !== exp || dwell !== DW'(dw)) begin
         errors++;
         $display("FAIL %s: got r/g/y/sv/step/ill/skip/to/short=%b dwell=%0d, want %b dwell=%0d",
                  name, act, dwell, exp, dw);
      end else begin
         $display("ok   %s: outs=%b dwell=%0d", name, act, dwell);
      end
   endtask

   function automatic logic short_exp(input logic sh);
`ifdef MIN_DWELL_EN
      return sh;
`else
      return 1'b0 & sh;
`endif
   endfunction

   initial begin
      //   q    clr n   lamps sv stp dw  ill skp tmo sh
      add(2'b00, 0, 1,  R, 1, 0, 0,  0, 0, 0, 0);
      add(2'b00, 0, 8,  R, 1, 0, 8,  0, 0, 0, 0);
      add(2'b01, 0, 2,  R, 1, 0, 10, 0, 0, 0, 0);
      add(2'b01, 0, 1,  G, 1, 1, 0,  0, 0, 0, 0);
      add(2'b01, 0, 1,  G, 1, 0, 1,  0, 0, 0, 0);
      add(2'b01, 0, 10, G, 1, 0, 11, 0, 0, 0, 0);
      add(2'b10, 0, 3,  Y, 1, 1, 0,  0, 0, 0, 0);
      add(2'b10, 0, 8,  Y, 1, 0, 8,  0, 0, 0, 0);
      add(2'b00, 0, 3,  R, 1, 1, 0,  0, 0, 0, 0);
      add(2'b00, 0, 2,  R, 1, 0, 2,  0, 0, 0, 0);
      add(2'b11, 0, 3,  R, 0, 0, 0,  1, 0, 0, 0);
      add(2'b11, 0, 2,  R, 0, 0, 0,  1, 0, 0, 0);
      add(2'b01, 0, 3,  G, 1, 0, 0,  1, 0, 0, 0);
      add(2'b01, 0, 2,  G, 1, 0, 2,  1, 0, 0, 0);
      add(2'b01, 1, 1,  G, 1, 0, 3,  0, 0, 0, 0);
      add(2'b01, 0, 5,  G, 1, 0, 8,  0, 0, 0, 0);
      add(2'b10, 0, 3,  Y, 1, 1, 0,  0, 0, 0, 0);
      add(2'b10, 0, 2,  Y, 1, 0, 2,  0, 0, 0, 0);
      add(2'b01, 0, 3,  G, 1, 0, 0,  0, 1, 0, 0);
      add(2'b01, 0, 2,  G, 1, 0, 2,  0, 1, 0, 0);
      add(2'b00, 0, 2,  G, 1, 0, 4,  0, 1, 0, 0);
      add(2'b00, 1, 1,  R, 1, 0, 0,  0, 1, 0, 0);
      add(2'b00, 1, 1,  R, 1, 0, 1,  0, 0, 0, 0);
      add(2'b00, 0, 7,  R, 1, 0, 8,  0, 0, 0, 0);
      add(2'b01, 0, 3,  G, 1, 1, 0,  0, 0, 0, 0);
      add(2'b01, 0, 8,  G, 1, 0, 8,  0, 0, 0, 0);
      add(2'b10, 0, 3,  Y, 1, 1, 0,  0, 0, 0, 0);
      add(2'b10, 0, 15, Y, 1, 0, 15, 0, 0, 0, 0);
      add(2'b10, 0, 1,  Y, 1, 0, 16, 0, 0, 1, 0);
      add(2'b10, 0, 21, Y, 1, 0, 37, 0, 0, 1, 0);
      add(2'b10, 1, 1,  Y, 1, 0, 38, 0, 0, 0, 0);
      add(2'b10, 0, 1,  Y, 1, 0, 39, 0, 0, 0, 0);
      add(2'b00, 0, 3,  R, 1, 1, 0,  0, 0, 0, 0);
      add(2'b00, 0, 1,  R, 1, 0, 1,  0, 0, 0, 0);
      add(2'b01, 0, 3,  G, 1, 1, 0,  0, 0, 0, 1);
      add(2'b01, 1, 1,  G, 1, 0, 1,  0, 0, 0, 0);

      reset     = 1'b0;
      q_in      = 2'b00;
      clear_err = 1'b0;
      tick();
      tick();
      check("reset_state", R, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         q_in      = tbl[i].q;
         clear_err = tbl[i].clr;
         for (int c = 0; c < tbl[i].n; c++)
            tick();
         check($sformatf("vec%0d", i), tbl[i].lamps, tbl[i].sv, tbl[i].stp, tbl[i].dw,
               tbl[i].ill, tbl[i].skp, tbl[i].tmo, short_exp(tbl[i].sh));
      end
      clear_err = 1'b0;

      // Asynchronous reset in the middle of a cycle while an error is held
      q_in = 2'b11;
      tick();
      tick();
      tick();
      check("pre_reset_illegal", R, 0, 0, 0, 1, 0, 0, 0);
      #3 reset = 1'b0;
      #1 check("async_reset", R, 0, 0, 0, 0, 0, 0, 0);
      q_in = 2'b00;
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("restart_init", R, 1, 0, 0, 0, 0, 0, 0);
      tick();
      check("restart_count", R, 1, 0, 1, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
